// File: rtl/fdiv_seq.sv
// fdiv_seq: issue/collect sequencer around the pipelined fp32 divider fdiv, with tagged in-order results
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_a/in_b/in_op/in_tag request handshake;
// div_a/div_b/div_op registered operands to fdiv, div_q its result; out_valid/out_ready/out_q/out_tag
// result handshake from the FIFO head; busy while anything is in flight or buffered.
// Optional macro FDIV_SEQ_FLUSH_EN adds a flush input that discards all in-flight and buffered results.
module fdiv_seq #(
  parameter int LATENCY = 1,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef FDIV_SEQ_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  output logic [1:0]       div_op,
  input  logic [31:0]      div_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_q,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEP = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic fl;
`ifdef FDIV_SEQ_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif
  logic [LATENCY:0] pv;
  logic [TAG_W-1:0] pt [LATENCY+1];
  logic [31:0] mq [DEPTH];
  logic [TAG_W-1:0] mt [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] icnt, fcnt, occ;
  logic acc, cap, pop;
  // Credits cover in-flight plus buffered work, so a capture always finds a free FIFO slot.
  assign occ = icnt + fcnt;
  assign in_ready = ~fl & (occ < DEP);
  assign busy = occ != '0;
  assign out_valid = fcnt != '0;
  assign out_q = mq[rp];
  assign out_tag = mt[rp];
  assign acc = in_valid & in_ready;
  assign cap = pv[LATENCY];
  assign pop = out_valid & out_ready & ~fl;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_a <= '0;
      div_b <= '0;
      div_op <= '0;
      pv <= '0;
      wp <= '0;
      rp <= '0;
      icnt <= '0;
      fcnt <= '0;
      for (int i = 0; i <= LATENCY; i++) pt[i] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mq[i] <= '0;
        mt[i] <= '0;
      end
    end else if (fl) begin
      pv <= '0;
      wp <= '0;
      rp <= '0;
      icnt <= '0;
      fcnt <= '0;
    end else begin
      if (acc) begin
        div_a <= in_a;
        div_b <= in_b;
        div_op <= in_op;
      end
      pv <= {pv[LATENCY-1:0], acc};
      pt[0] <= in_tag;
      for (int i = 1; i <= LATENCY; i++) pt[i] <= pt[i-1];
      if (cap) begin
        mq[wp] <= div_q;
        mt[wp] <= pt[LATENCY];
        wp <= (wp == LAST) ? '0 : wp + 1'b1;
      end
      if (pop) rp <= (rp == LAST) ? '0 : rp + 1'b1;
      icnt <= icnt + CW'(acc) - CW'(cap);
      fcnt <= fcnt + CW'(cap) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: self-checking bench for fdiv_seq with a behavioural fdiv stand-in and a queue scoreboard
module tb_fdiv_seq;
  localparam int LATENCY = 1;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic rst_n = 1;
  logic flush = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [31:0] in_a = 0;
  logic [31:0] in_b = 0;
  logic [1:0] in_op = 0;
  logic [TAG_W-1:0] in_tag = 0;
  logic [31:0] div_a, div_b;
  logic [1:0] div_op;
  logic [31:0] div_q = 0;
  logic out_valid;
  logic out_ready = 0;
  logic [31:0] out_q;
  logic [TAG_W-1:0] out_tag;
  logic busy;
  fdiv_seq #(.LATENCY(LATENCY), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef FDIV_SEQ_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_op(in_op),
    .in_tag(in_tag),
    .div_a(div_a),
    .div_b(div_b),
    .div_op(div_op),
    .div_q(div_q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_q(out_q),
    .out_tag(out_tag),
    .busy(busy)
  );
  always #5 clk = ~clk;
  // Stand-in for fdiv: exact quotients for the known vectors, a scrambling function otherwise.
  function automatic logic [31:0] fdiv_ref(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    case ({a, b})
      {32'h3f800000, 32'h3f000000}: return 32'h40000000;
      {32'h40490fdb, 32'h402df854}: return 32'h3f93eee0;
      {32'h402df854, 32'h40490fdb}: return 32'h3f5d816a;
      {32'h3f800000, 32'h3f800000}: return 32'h3f800000;
      {32'h3f800000, 32'h00000000}: return 32'h7f800000;
      {32'h00000000, 32'h3f800000}: return 32'h00000000;
      default: return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
    endcase
  endfunction
  always @(posedge clk) div_q <= fdiv_ref(div_a, div_b, div_op);
  typedef struct {
    logic [31:0] q;
    logic [TAG_W-1:0] t;
    int e;
  } ent_t;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [TAG_W-1:0] t;
    logic [31:0] q;
  } vec_t;
  ent_t sb[$];
  logic [31:0] got_q[$];
  logic [TAG_W-1:0] got_t[$];
  int got_c[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cnt = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk1(string nm, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask
  // One cycle: sample between edges, score the handshakes that the next edge will perform, advance.
  task automatic tick();
    ent_t e;
    logic exp_ov;
    #1;
    exp_ov = (sb.size() > 0) ? (cyc >= sb[0].e + LATENCY + 1) : 1'b0;
    chk1("out_valid", out_valid, exp_ov);
    chk1("in_ready", in_ready, !flush && sb.size() < DEPTH);
    chk1("busy", busy, sb.size() != 0);
    if (out_valid && out_ready && !flush) begin
      got_q.push_back(out_q);
      got_t.push_back(out_tag);
      got_c.push_back(cyc);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_q", out_q, e.q);
        chk("sb_tag", 32'(out_tag), 32'(e.t));
      end
    end
    if (in_valid && in_ready && !flush) begin
      acc_cnt++;
      sb.push_back('{fdiv_ref(in_a, in_b, in_op), in_tag, cyc + 1});
    end
    if (flush) sb.delete();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  task automatic issue(logic [31:0] a, logic [31:0] b, logic [TAG_W-1:0] t);
    in_valid = 1;
    in_a = a;
    in_b = b;
    in_op = 2'($urandom);
    in_tag = t;
    tick();
    in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    out_ready = 1;
    in_valid = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      tick();
      n++;
    end
    chk1("drain_done", n < 100, 1'b1);
  endtask
  initial begin
    vec_t tbl[5];
    tbl[0] = '{32'h40490fdb, 32'h402df854, 4'd1, 32'h3f93eee0};
    tbl[1] = '{32'h402df854, 32'h40490fdb, 4'd2, 32'h3f5d816a};
    tbl[2] = '{32'h3f800000, 32'h3f800000, 4'd3, 32'h3f800000};
    tbl[3] = '{32'h3f800000, 32'h00000000, 4'd4, 32'h7f800000};
    tbl[4] = '{32'h00000000, 32'h3f800000, 4'd5, 32'h00000000};
    #1 rst_n = 0;
    @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_q", out_q, 32'h0);
    chk("rst_out_tag", 32'(out_tag), 32'h0);
    chk("rst_div_a", div_a, 32'h0);
    chk("rst_div_b", div_b, 32'h0);
    chk("rst_div_op", 32'(div_op), 32'h0);
    rst_n = 1;
    @(negedge clk);
    // Single op: result visible two edges after acceptance.
    out_ready = 1;
    issue(32'h3f800000, 32'h3f000000, 4'd3);
    chk("single_div_a", div_a, 32'h3f800000);
    chk("single_div_b", div_b, 32'h3f000000);
    chk1("single_lat_edge0", out_valid, 1'b0);
    tick();
    chk1("single_lat_edge1", out_valid, 1'b0);
    tick();
    chk1("single_lat_edge2", out_valid, 1'b1);
    chk("single_q", out_q, 32'h40000000);
    chk("single_tag", 32'(out_tag), 32'd3);
    drain();
    // Back-to-back table vectors, including boundary values: one result per cycle, in order.
    got_q.delete();
    got_t.delete();
    got_c.delete();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1;
      in_a = tbl[k].a;
      in_b = tbl[k].b;
      in_op = 0;
      in_tag = tbl[k].t;
      tick();
    end
    drain();
    chk("tbl_count", 32'(got_q.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < got_q.size()) begin
        chk($sformatf("tbl_q%0d", k), got_q[k], tbl[k].q);
        chk($sformatf("tbl_tag%0d", k), 32'(got_t[k]), 32'(tbl[k].t));
        if (k > 0) chk($sformatf("tbl_gap%0d", k), 32'(got_c[k] - got_c[k-1]), 32'd1);
      end
    end
    // Back-pressure: only DEPTH credits are granted.
    out_ready = 0;
    acc_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1;
      in_a = $urandom;
      in_b = $urandom;
      in_op = 2'($urandom);
      in_tag = TAG_W'(k + 8);
      tick();
    end
    in_valid = 0;
    chk("bp_accepted", 32'(acc_cnt), 32'(DEPTH));
    chk1("bp_in_ready", in_ready, 1'b0);
    chk1("bp_busy", busy, 1'b1);
    out_ready = 1;
    tick();
    chk1("bp_ready_after_pop", in_ready, 1'b1);
    drain();
    // Randomized traffic against the scoreboard.
    for (int k = 0; k < 400; k++) begin
      in_valid = $urandom_range(0, 1) == 1;
      in_a = $urandom;
      in_b = $urandom;
      in_op = 2'($urandom);
      in_tag = TAG_W'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    drain();
    // Asynchronous reset with three results buffered.
    out_ready = 0;
    for (int k = 0; k < 3; k++) issue($urandom, $urandom, TAG_W'(k + 1));
    tick();
    tick();
    chk1("pre_rst_valid", out_valid, 1'b1);
    #2 rst_n = 0;
    #1;
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_q", out_q, 32'h0);
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    repeat (5) tick();
    issue(32'h3f800000, 32'h3f800000, 4'd6);
    drain();
`ifdef FDIV_SEQ_FLUSH_EN
    // Flush with two buffered and two in flight; a same-edge pop and request are ignored.
    out_ready = 0;
    issue($urandom, $urandom, 4'd1);
    issue($urandom, $urandom, 4'd2);
    tick();
    tick();
    issue($urandom, $urandom, 4'd3);
    issue($urandom, $urandom, 4'd4);
    flush = 1;
    in_valid = 1;
    out_ready = 1;
    tick();
    flush = 0;
    in_valid = 0;
    chk1("flush_out_valid", out_valid, 1'b0);
    chk1("flush_busy", busy, 1'b0);
    got_q.delete();
    got_t.delete();
    got_c.delete();
    issue(32'h3f800000, 32'h3f000000, 4'd7);
    drain();
    chk("flush_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) begin
      chk("flush_q", got_q[0], 32'h40000000);
      chk("flush_tag", 32'(got_t[0]), 32'd7);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
